planificador_cuenta: RTL and testbench
======================================

Name: planificador_cuenta

Overview:
Round-robin scheduler that shares one cuenta1-style counting unit between N_REQ requesters. It grants one requester, latches that requester's operand and launches the counter with a one-cycle start pulse. It then waits for the counter's fin, or a timeout, and returns the captured result with a one-cycle done pulse to the granted requester. It sits between the requester ports and a single counter instance in the top-level datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
W_IN, 3, operand width (counter entrada)
W_OUT, 4, result width (counter salida)
TIMEOUT, 32, max WAIT cycles before the job is aborted with error (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  level request per requester; held until its done pulse
op_in  in  N_REQ*W_IN  packed operands; requester i at bits [i*W_IN +: W_IN]
done  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester
result  out  W_OUT  result of the last completed job; valid while done is high, held until the next REPORT
err  out  1  high with done when the job timed out; held like result
busy  out  1  high in every state except IDLE
cnt_entrada  out  W_IN  operand to counter; stable from LAUNCH through end of WAIT
cnt_start  out  1  one-cycle launch pulse to counter
cnt_salida  in  W_OUT  counter result
cnt_fin  in  1  counter completion flag

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr pointer=0; all outputs 0 (done, result, err, busy, cnt_start, cnt_entrada); timer=0.
  - Reset mid-job aborts the job silently: no done pulse, next cycle is IDLE.
- FSM states: IDLE -> LAUNCH -> WAIT -> REPORT -> IDLE.
- IDLE:
  - If any req bit is high, grant the first high bit searching upward from ptr, wrapping modulo N_REQ.
  - Register the grant index g and latch op_in slice g into cnt_entrada; go to LAUNCH.
  - If no req is high, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - cnt_start=1; clear timer; go to WAIT.
  - cnt_fin is ignored in this cycle (it may be stale from the previous job).
- WAIT:
  - cnt_start=0; timer increments every cycle.
  - If cnt_fin=1: capture cnt_salida into result, set err=0, go to REPORT.
  - Else if timer==TIMEOUT-1: set result=0, err=1, go to REPORT.
  - If cnt_fin and timeout coincide, cnt_fin wins (err=0).
- REPORT (1 cycle):
  - done[g]=1; ptr=(g+1) mod N_REQ; next state IDLE.
  - IDLE re-arbitrates in the following cycle, so there is at least 1 idle cycle between jobs.
- Latency:
  - req high while IDLE in cycle c -> cnt_start high in c+1.
  - First WAIT cycle is c+2.
  - cnt_fin first high in cycle f (f>=c+2) -> done high in f+1.
  - Minimum request-to-done is 3 cycles.
- Request rules:
  - Operand changes after the grant have no effect on the current job.
  - req deasserted before the grant: not serviced.
  - req deasserted after the grant: the job completes and done is still pulsed.
  - A requester holding req after its done pulse is treated as a new request, subject to round-robin order.
- Fairness: with all req high, the grant sequence is 0,1,...,N_REQ-1,0,...
- Width: timer is $clog2(TIMEOUT+1) bits; it never wraps because it is cleared in LAUNCH.

Test Plan:
1. Single request: reset 2 cycles; req=0001, op_in[2:0]=3'b101; the counter model asserts fin 4 cycles after start with salida=4'b0010 -> cnt_start pulses once with cnt_entrada=101; done=0001 one cycle after fin; result=0010, err=0, busy low the next cycle.
2. Round-robin: req=1111 held, operands 1,2,3,4, counter echoes {0,entrada} -> done order 0001,0010,0100,1000,0001; results 1,2,3,4,1.
3. Timeout: TIMEOUT=8, req=0100, counter never asserts fin -> done=0100 exactly 9 cycles after cnt_start (LAUNCH + 8 WAIT + REPORT alignment); err=1, result=0; the next job completes normally with err=0.
4. Fin/timeout tie and stale fin: fin asserted on the last WAIT cycle -> err=0 with the captured result. fin held high during LAUNCH -> ignored; capture happens on the first WAIT cycle.
5. Reset mid-WAIT: assert reset for 1 cycle during a job -> no done pulse, all outputs 0, ptr=0; a subsequent req=0010 is granted normally.
6. Request withdrawal: req=0011 with ptr=0; drop req[0] the cycle after the grant -> job 0 still completes with done=0001; req[1] is serviced next; operand changes during WAIT do not alter cnt_entrada.

Source files
------------

// File: rtl/planificador_cuenta.sv
// planificador_cuenta: round-robin scheduler that shares a single counting
// unit between N_REQ requesters. One job at a time: grant, launch the
// counter with a one-cycle start pulse, wait for fin or a timeout, then
// report the result with a one-cycle done pulse to the granted requester.
module planificador_cuenta #(
  parameter int N_REQ   = 4,
  parameter int W_IN    = 3,
  parameter int W_OUT   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*W_IN-1:0]   op_in,
  output logic [N_REQ-1:0]        done,
  output logic [W_OUT-1:0]        result,
  output logic                    err,
  output logic                    busy,
  output logic [W_IN-1:0]         cnt_entrada,
  output logic                    cnt_start,
  input  logic [W_OUT-1:0]        cnt_salida,
  input  logic                    cnt_fin
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  gnt_r;
  logic [TMR_W-1:0]  timer_r;
  logic [N_REQ-1:0]  done_r;
  logic [W_OUT-1:0]  result_r;
  logic              err_r;
  logic              busy_r;
  logic [W_IN-1:0]   entrada_r;
  logic              start_r;

  logic              any_found_s;
  logic              up_found_s;
  logic [IDX_W-1:0]  any_idx_s;
  logic [IDX_W-1:0]  up_idx_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic [W_IN-1:0]   op_sel_s;

  // Round-robin pick: the lowest requesting index at or above ptr wins;
  // if none exists the search wraps to the lowest requesting index overall.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    any_found_s = 1'b0;
    up_found_s  = 1'b0;
    any_idx_s   = {IDX_W{1'b0}};
    up_idx_s    = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      any_found_s = any_found_s | req[i];
      any_idx_s   = req[i] ? IDX_W'(i) : any_idx_s;
      up_found_s  = up_found_s | (req[i] & (i >= int'(ptr_r)));
      up_idx_s    = (req[i] && (i >= int'(ptr_r))) ? IDX_W'(i) : up_idx_s;
    end
    grant_idx_s = up_found_s ? up_idx_s : any_idx_s;
    op_sel_s    = op_in[int'(grant_idx_s)*W_IN +: W_IN];
  end

  // Scheduler FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {IDX_W{1'b0}};
      gnt_r     <= {IDX_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
      done_r    <= {N_REQ{1'b0}};
      result_r  <= {W_OUT{1'b0}};
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      entrada_r <= {W_IN{1'b0}};
      start_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_found_s) begin
            // Operand is frozen here; later op_in changes cannot touch this job.
            gnt_r     <= grant_idx_s;
            entrada_r <= op_sel_s;
            start_r   <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_LAUNCH;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          // cnt_fin may still be high from the previous job, so it is not looked at here.
          start_r <= 1'b0;
          timer_r <= {TMR_W{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          timer_r <= timer_r + TMR_W'(1);
          // fin is tested first so that it wins a tie with the timeout.
          if (cnt_fin) begin
            result_r <= cnt_salida;
            err_r    <= 1'b0;
            done_r   <= ONE_HOT0 << gnt_r;
            state_r  <= ST_REPORT;
          end else if (timer_r == TMR_LAST) begin
            result_r <= {W_OUT{1'b0}};
            err_r    <= 1'b1;
            done_r   <= ONE_HOT0 << gnt_r;
            state_r  <= ST_REPORT;
          end else begin
            state_r  <= ST_WAIT;
          end
        end
        ST_REPORT: begin
          done_r  <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          ptr_r   <= (gnt_r == LAST_IDX) ? {IDX_W{1'b0}} : gnt_r + IDX_W'(1);
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= {N_REQ{1'b0}};
          start_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign done        = done_r;
  assign result      = result_r;
  assign err         = err_r;
  assign busy        = busy_r;
  assign cnt_entrada = entrada_r;
  assign cnt_start   = start_r;

endmodule

// File: tb/tb_planificador_cuenta.sv
// Self-checking bench for planificador_cuenta: a cycle-stamped job model
// compared every cycle, a programmable counter emulation, and directed
// scenarios with hand-computed expectations.
module tb_planificador_cuenta;

  localparam int N  = 4;
  localparam int WI = 3;
  localparam int WO = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*WI-1:0] op_in;
  logic [N-1:0]  done;
  logic [WO-1:0] result;
  logic          err;
  logic          busy;
  logic [WI-1:0] cnt_entrada;
  logic          cnt_start;
  logic [WO-1:0] cnt_salida = 4'd0;
  logic          cnt_fin    = 1'b0;

  planificador_cuenta #(.N_REQ(N), .W_IN(WI), .W_OUT(WO), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .op_in(op_in),
    .done(done), .result(result), .err(err), .busy(busy),
    .cnt_entrada(cnt_entrada), .cnt_start(cnt_start),
    .cnt_salida(cnt_salida), .cnt_fin(cnt_fin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int last_start_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Counter emulation: fin rises ctr_delay cycles after start (0 = during
  // the launch cycle itself, -1 = never) and stays high until the next start.
  int          ctr_delay = 1;
  bit          ctr_echo  = 1'b0;
  logic [WO-1:0] ctr_val = 4'd0;
  logic [WO-1:0] pend_val = 4'd0;
  int          rem = 0;

  always @(posedge clk) begin
    #2;
    if (cnt_start === 1'b1) begin
      pend_val = ctr_echo ? WO'(cnt_entrada) : ctr_val;
      if (ctr_delay == 0) begin
        cnt_fin    = 1'b1;
        cnt_salida = pend_val;
        rem        = 0;
      end else begin
        cnt_fin = 1'b0;
        rem     = ctr_delay;
      end
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        cnt_fin    = 1'b1;
        cnt_salida = pend_val;
      end
    end
  end

  // Job model: cycle stamps for launch and report, round-robin by modulo search.
  bit          m_active = 1'b0;
  int          m_g = 0, m_ptr = 0, m_start = -1, m_done = -1;
  logic [WO-1:0] m_res = 4'd0;
  logic        m_err = 1'b0;
  logic [WI-1:0] m_ent = 3'd0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_active = 1'b0; m_ptr = 0; m_res = 4'd0; m_err = 1'b0; m_ent = 3'd0;
      m_start = -1; m_done = -1;
    end else if (!m_active) begin
      if (req != 4'd0) begin
        m_g      = rr_pick(req, m_ptr);
        m_ent    = op_in[m_g*WI +: WI];
        m_start  = cyc + 1;
        m_done   = -1;
        m_active = 1'b1;
      end
    end else if (m_done < 0) begin
      if (cyc > m_start) begin
        if (cnt_fin) begin
          m_done = cyc + 1; m_res = cnt_salida; m_err = 1'b0;
        end else if (cyc - m_start == TO) begin
          m_done = cyc + 1; m_res = 4'd0; m_err = 1'b1;
        end
      end
    end else if (cyc == m_done) begin
      m_active = 1'b0;
      m_ptr    = (m_g + 1) % N;
    end
    cyc++;
  end

  // Every-cycle comparison of all outputs against the job model.
  always @(negedge clk) begin
    if (cnt_start === 1'b1) last_start_cyc = cyc;
    if (chk_en) begin
      chk("m_done",    32'(done),        (m_active && cyc == m_done) ? (32'd1 << m_g) : 32'd0);
      chk("m_start",   32'(cnt_start),   32'(m_active && cyc == m_start));
      chk("m_busy",    32'(busy),        32'(m_active));
      chk("m_entrada", 32'(cnt_entrada), 32'(m_ent));
      chk("m_result",  32'(result),      32'(m_res));
      chk("m_err",     32'(err),         32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input string nm, input logic [WI-1:0] exp_ent);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #2; n++;
      if (cnt_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_start: no cnt_start within 50 cycles", nm);
    end else begin
      chk({nm, "_entrada"}, 32'(cnt_entrada), 32'(exp_ent));
    end
  endtask

  task automatic wait_done(input string nm, input logic [N-1:0] exp_done,
                           input logic [WO-1:0] exp_res, input logic exp_err, input int exp_lat);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk); n++;
      if (done !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: no done pulse within 60 cycles", nm);
    end else begin
      chk({nm, "_done"},   32'(done),   32'(exp_done));
      chk({nm, "_result"}, 32'(result), 32'(exp_res));
      chk({nm, "_err"},    32'(err),    32'(exp_err));
      chk({nm, "_lat"},    32'(cyc - last_start_cyc), 32'(exp_lat));
    end
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input int n);
    req = 4'd0;
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'd0; op_in = '0;

    // Reset state.
    tick(2);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_start", 32'(cnt_start), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    tick(1);

    // 1: single request, fin 4 cycles after start.
    ctr_echo = 1'b0; ctr_delay = 4; ctr_val = 4'b0010;
    op_in = 12'b000_000_000_101; req = 4'b0001;
    wait_start("t1", 3'b101);
    wait_done("t1", 4'b0001, 4'b0010, 1'b0, 5);
    req = 4'd0;
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);
    tick(1);

    // 2: round-robin with all requests held, counter echoes the operand.
    do_reset(2);
    ctr_echo = 1'b1; ctr_delay = 2;
    op_in = {3'd4, 3'd3, 3'd2, 3'd1}; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done("t2", 4'b0001 << (i % N), WO'((i % N) + 1), 1'b0, 3);
    end
    req = 4'd0;
    tick(2);

    // 3: timeout, then a normal job from the same requester.
    ctr_echo = 1'b0; ctr_delay = -1;
    op_in = {3'd0, 3'd6, 3'd0, 3'd0}; req = 4'b0100;
    wait_start("t3a", 3'd6);
    wait_done("t3a", 4'b0100, 4'd0, 1'b1, 9);
    ctr_delay = 3; ctr_val = 4'hA;
    wait_start("t3b", 3'd6);
    wait_done("t3b", 4'b0100, 4'hA, 1'b0, 4);
    req = 4'd0;
    tick(2);

    // 4: fin on the last WAIT cycle, then fin held high through LAUNCH.
    ctr_delay = 8; ctr_val = 4'h7;
    op_in = {3'd1, 9'd0}; req = 4'b1000;
    wait_start("t4a", 3'd1);
    wait_done("t4a", 4'b1000, 4'h7, 1'b0, 9);
    ctr_delay = 0; ctr_val = 4'h5;
    wait_start("t4b", 3'd1);
    wait_done("t4b", 4'b1000, 4'h5, 1'b0, 2);
    req = 4'd0;
    tick(2);

    // 5: reset during WAIT, then a fresh request.
    ctr_delay = -1;
    op_in = {9'd0, 3'd2}; req = 4'b0001;
    wait_start("t5a", 3'd2);
    tick(3);
    do_reset(1);
    @(negedge clk);
    chk("t5_rst_done",    32'(done), 32'd0);
    chk("t5_rst_busy",    32'(busy), 32'd0);
    chk("t5_rst_entrada", 32'(cnt_entrada), 32'd0);
    chk("t5_rst_err",     32'(err), 32'd0);
    tick(1);
    ctr_echo = 1'b1; ctr_delay = 1;
    op_in = {6'd0, 3'd3, 3'd0}; req = 4'b0010;
    wait_start("t5b", 3'd3);
    wait_done("t5b", 4'b0010, 4'd3, 1'b0, 2);
    req = 4'd0;
    tick(2);

    // 6: requester 0 withdraws after its grant, operand changes mid-job.
    ctr_echo = 1'b1; ctr_delay = 3;
    op_in = {6'd0, 3'd5, 3'd2}; req = 4'b0011;
    wait_start("t6a", 3'd2);
    req = 4'b0010;
    op_in[2:0] = 3'd7;
    tick(1);
    @(negedge clk);
    chk("t6_entrada_held", 32'(cnt_entrada), 32'd2);
    wait_done("t6a", 4'b0001, 4'd2, 1'b0, 4);
    wait_start("t6b", 3'd5);
    wait_done("t6b", 4'b0010, 4'd5, 1'b0, 4);
    req = 4'd0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
